spio_hss_multiplexer_frame_rx: RTL and testbench



---
 rtl/spio_hss_multiplexer_frame_rx_pkg.sv | 58 +++++
 rtl/spio_hss_multiplexer_frame_rx_if.sv | 30 +++
 rtl/spio_hss_multiplexer_rx_pkt_buf.sv | 48 ++++
 rtl/spio_hss_multiplexer_frame_rx.sv | 169 ++++++++++++++++
 tb/tb_spio_hss_multiplexer_frame_rx.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/spio_hss_multiplexer_frame_rx_pkg.sv
// Shared constants, word classes and FSM state type for the HSS multiplexer frame receiver.
// Used by the interface, the per-channel packet buffer and the receiver top.
package spio_hss_multiplexer_frame_rx_pkg;

    localparam int PKT_BITS = 72;
    localparam int NUM_CH   = 8;
    localparam int CH_BITS  = 3;

    localparam logic [7:0] K_SOF  = 8'hFB;
    localparam logic [7:0] K_EOF  = 8'hFD;
    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [3:0] KFLAG_CTRL = 4'b1000;

    localparam int CTRL_PAYLOAD_BIT = 1;
    localparam int CH_LSB           = 0;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_KEY,
        ST_PAYLOAD,
        ST_EOF
    } rx_state_e;

    typedef enum logic [2:0] {
        W_SOF,
        W_EOF,
        W_IDLE,
        W_DATA,
        W_BAD
    } word_cls_e;

    typedef struct packed {
        logic [31:0] payload;
        logic [31:0] key;
        logic [7:0]  ctrl;
    } pkt_t;

    function automatic word_cls_e classify(input logic [31:0] d, input logic [3:0] k);
        word_cls_e c;
        c = W_BAD;
        if (k == 4'b0000) begin
            c = W_DATA;
        end else if (k == KFLAG_CTRL) begin
            case (d[31:24])
                K_SOF:   c = W_SOF;
                K_EOF:   c = W_EOF;
                K_IDLE:  c = W_IDLE;
                default: c = W_BAD;
            endcase
        end
        return c;
    endfunction

    function automatic logic [15:0] fold16(input logic [31:0] w);
        return w[31:16] ^ w[15:0];
    endfunction

endpackage

// File: rtl/spio_hss_multiplexer_frame_rx_if.sv
// Bundles the RX word stream, the eight packet outputs and the statistics counters.
// The slave modport is the receiver; master is its environment.
interface spio_hss_multiplexer_frame_rx_if #(parameter int CNT_BITS = 16);
    import spio_hss_multiplexer_frame_rx_pkg::*;

    logic                         HANDSHAKE_COMPLETE_IN;
    logic [31:0]                  RXDATA_IN;
    logic [3:0]                   RXCHARISK_IN;
    logic                         RXVLD_IN;
    logic [NUM_CH*PKT_BITS-1:0]   RX_PKT_DATA_OUT;
    logic [NUM_CH-1:0]            RX_PKT_VLD_OUT;
    logic [NUM_CH-1:0]            RX_PKT_RDY_IN;
    logic [CNT_BITS-1:0]          FRAMES_OK_OUT;
    logic [CNT_BITS-1:0]          CRC_ERR_OUT;
    logic [CNT_BITS-1:0]          FRAMING_ERR_OUT;
    logic [CNT_BITS-1:0]          DROPPED_OUT;

    modport slave (
        input  HANDSHAKE_COMPLETE_IN, RXDATA_IN, RXCHARISK_IN, RXVLD_IN, RX_PKT_RDY_IN,
        output RX_PKT_DATA_OUT, RX_PKT_VLD_OUT,
        output FRAMES_OK_OUT, CRC_ERR_OUT, FRAMING_ERR_OUT, DROPPED_OUT
    );

    modport master (
        output HANDSHAKE_COMPLETE_IN, RXDATA_IN, RXCHARISK_IN, RXVLD_IN, RX_PKT_RDY_IN,
        input  RX_PKT_DATA_OUT, RX_PKT_VLD_OUT,
        input  FRAMES_OK_OUT, CRC_ERR_OUT, FRAMING_ERR_OUT, DROPPED_OUT
    );

endinterface

// File: rtl/spio_hss_multiplexer_rx_pkt_buf.sv
// One-entry valid/ready packet buffer; load is accepted if empty or draining this cycle.
// Latency 1 cycle load-to-valid; a load into a full, stalled buffer is dropped and flagged.
module spio_hss_multiplexer_rx_pkt_buf
    import spio_hss_multiplexer_frame_rx_pkg::*;
(
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic                load_i,
    input  logic [PKT_BITS-1:0] dat_i,
    input  logic                rdy_i,
    output logic                vld_o,
    output logic [PKT_BITS-1:0] dat_o,
    output logic                drop_o
);

    logic                vld_q, vld_d;
    logic [PKT_BITS-1:0] dat_q, dat_d;

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        drop_o = 1'b0;
        if (load_i) begin
            if (!vld_q || rdy_i) begin
                vld_d = 1'b1;
                dat_d = dat_i;
            end else begin
                drop_o = 1'b1;
            end
        end else if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/spio_hss_multiplexer_frame_rx.sv
// Parses SOF/KEY/[PAYLOAD]/EOF frames, checks the XOR checksum and demuxes packets to 8 channels.
// Latency: EOF accepted in cycle N gives valid in N+1; no input backpressure, full stalled buffers drop.
// Statistics counters exist only when SPIO_HSS_FRAME_RX_STATS_EN is defined.
module spio_hss_multiplexer_frame_rx
    import spio_hss_multiplexer_frame_rx_pkg::*;
#(
    parameter int CNT_BITS = 16
) (
    input  logic CLK_IN,
    input  logic RESET_IN,
    spio_hss_multiplexer_frame_rx_if.slave bus
);

    rx_state_e          state_q, state_d;
    logic [7:0]         ctrl_q, ctrl_d;
    logic [CH_BITS-1:0] chan_q, chan_d;
    logic [31:0]        key_q, key_d;
    logic [31:0]        pay_q, pay_d;
    logic [15:0]        csum_q, csum_d;

    word_cls_e cls;
    logic      word_ok;
    logic      start;
    logic      deliver;
    logic      inc_ok, inc_crc, inc_frm, inc_drop;
    pkt_t      cur_pkt;

    assign cls     = classify(bus.RXDATA_IN, bus.RXCHARISK_IN);
    assign word_ok = bus.HANDSHAKE_COMPLETE_IN && bus.RXVLD_IN && (cls != W_IDLE);

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        chan_d  = chan_q;
        key_d   = key_q;
        pay_d   = pay_q;
        csum_d  = csum_q;
        start   = 1'b0;
        deliver = 1'b0;
        inc_ok  = 1'b0;
        inc_crc = 1'b0;
        inc_frm = 1'b0;

        if (!bus.HANDSHAKE_COMPLETE_IN) begin
            state_d = ST_HUNT;
        end else if (word_ok) begin
            case (state_q)
                ST_HUNT: begin
                    start = (cls == W_SOF);
                end
                ST_KEY: begin
                    if (cls == W_DATA) begin
                        key_d   = bus.RXDATA_IN;
                        csum_d  = csum_q ^ fold16(bus.RXDATA_IN);
                        state_d = ctrl_q[CTRL_PAYLOAD_BIT] ? ST_PAYLOAD : ST_EOF;
                    end else begin
                        inc_frm = 1'b1;
                        start   = (cls == W_SOF);
                        state_d = ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    if (cls == W_DATA) begin
                        pay_d   = bus.RXDATA_IN;
                        csum_d  = csum_q ^ fold16(bus.RXDATA_IN);
                        state_d = ST_EOF;
                    end else begin
                        inc_frm = 1'b1;
                        start   = (cls == W_SOF);
                        state_d = ST_HUNT;
                    end
                end
                ST_EOF: begin
                    if (cls == W_EOF) begin
                        if (csum_q == bus.RXDATA_IN[15:0]) begin
                            deliver = 1'b1;
                            inc_ok  = 1'b1;
                        end else begin
                            inc_crc = 1'b1;
                        end
                    end else begin
                        inc_frm = 1'b1;
                        start   = (cls == W_SOF);
                    end
                    state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // A new SOF always restarts capture; clearing the payload keeps it zero when absent.
        if (start) begin
            ctrl_d  = bus.RXDATA_IN[23:16];
            chan_d  = bus.RXDATA_IN[CH_LSB +: CH_BITS];
            key_d   = '0;
            pay_d   = '0;
            csum_d  = fold16(bus.RXDATA_IN);
            state_d = ST_KEY;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            state_q <= ST_HUNT;
            ctrl_q  <= '0;
            chan_q  <= '0;
            key_q   <= '0;
            pay_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            chan_q  <= chan_d;
            key_q   <= key_d;
            pay_q   <= pay_d;
            csum_q  <= csum_d;
        end
    end

    assign cur_pkt = '{payload: pay_q, key: key_q, ctrl: ctrl_q};

    logic [NUM_CH-1:0] drop_vec;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        spio_hss_multiplexer_rx_pkt_buf u_buf (
            .CLK_IN   (CLK_IN),
            .RESET_IN (RESET_IN),
            .load_i   (deliver && (chan_q == CH_BITS'(c))),
            .dat_i    (cur_pkt),
            .rdy_i    (bus.RX_PKT_RDY_IN[c]),
            .vld_o    (bus.RX_PKT_VLD_OUT[c]),
            .dat_o    (bus.RX_PKT_DATA_OUT[c*PKT_BITS +: PKT_BITS]),
            .drop_o   (drop_vec[c])
        );
    end

    assign inc_drop = |drop_vec;

`ifdef SPIO_HSS_FRAME_RX_STATS_EN
    logic [CNT_BITS-1:0] ok_q, crc_q, frm_q, drp_q;

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            ok_q  <= '0;
            crc_q <= '0;
            frm_q <= '0;
            drp_q <= '0;
        end else begin
            if (inc_ok  && (ok_q  != '1)) ok_q  <= ok_q  + CNT_BITS'(1);
            if (inc_crc && (crc_q != '1)) crc_q <= crc_q + CNT_BITS'(1);
            if (inc_frm && (frm_q != '1)) frm_q <= frm_q + CNT_BITS'(1);
            if (inc_drop && (drp_q != '1)) drp_q <= drp_q + CNT_BITS'(1);
        end
    end

    assign bus.FRAMES_OK_OUT   = ok_q;
    assign bus.CRC_ERR_OUT     = crc_q;
    assign bus.FRAMING_ERR_OUT = frm_q;
    assign bus.DROPPED_OUT     = drp_q;
`else
    logic unused_stats;
    assign unused_stats        = ^{inc_ok, inc_crc, inc_frm, inc_drop};
    assign bus.FRAMES_OK_OUT   = '0;
    assign bus.CRC_ERR_OUT     = '0;
    assign bus.FRAMING_ERR_OUT = '0;
    assign bus.DROPPED_OUT     = '0;
`endif

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_rx.sv
// Directed-vector bench for the HSS multiplexer frame receiver with hand-computed checksums.
module tb_spio_hss_multiplexer_frame_rx;
    import spio_hss_multiplexer_frame_rx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spio_hss_multiplexer_frame_rx_if bus ();

    spio_hss_multiplexer_frame_rx dut (
        .CLK_IN   (clk),
        .RESET_IN (rst_n),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cexp(input int v);
`ifdef SPIO_HSS_FRAME_RX_STATS_EN
        return 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    task automatic chk_cnts(input string tag, input int ok, input int crc, input int frm, input int drp);
        chk({tag, ".ok"},  72'(bus.FRAMES_OK_OUT),   72'(cexp(ok)));
        chk({tag, ".crc"}, 72'(bus.CRC_ERR_OUT),     72'(cexp(crc)));
        chk({tag, ".frm"}, 72'(bus.FRAMING_ERR_OUT), 72'(cexp(frm)));
        chk({tag, ".drp"}, 72'(bus.DROPPED_OUT),     72'(cexp(drp)));
    endtask

    task automatic word(input logic [31:0] d, input logic [3:0] k);
        @(negedge clk);
        bus.RXVLD_IN     = 1'b1;
        bus.RXDATA_IN    = d;
        bus.RXCHARISK_IN = k;
    endtask

    task automatic gap();
        @(negedge clk);
        bus.RXVLD_IN     = 1'b0;
        bus.RXDATA_IN    = '0;
        bus.RXCHARISK_IN = '0;
    endtask

    task automatic frame3(input logic [31:0] sof, input logic [31:0] key, input logic [31:0] eof);
        word(sof, 4'b1000);
        word(key, 4'b0000);
        word(eof, 4'b1000);
    endtask

    initial begin
        rst_n                     = 1'b0;
        bus.HANDSHAKE_COMPLETE_IN = 1'b1;
        bus.RXVLD_IN              = 1'b0;
        bus.RXDATA_IN             = '0;
        bus.RXCHARISK_IN          = '0;
        bus.RX_PKT_RDY_IN         = 8'hFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("reset.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h0);
        chk("reset.dat_ch2", bus.RX_PKT_DATA_OUT[2*PKT_BITS +: PKT_BITS], 72'h0);
        chk_cnts("reset", 0, 0, 0, 0);

        // Single frame on ch2: FB00^0002 ^ 1234^5678 = BF4E
        frame3(32'hFB00_0002, 32'h1234_5678, 32'hFD00_BF4E);
        chk("single.vld_before", 72'(bus.RX_PKT_VLD_OUT), 72'h0);
        gap();
        chk("single.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h04);
        chk("single.dat", bus.RX_PKT_DATA_OUT[2*PKT_BITS +: PKT_BITS], {32'h0, 32'h1234_5678, 8'h00});
        chk_cnts("single", 1, 0, 0, 0);
        gap();
        chk("single.consumed", 72'(bus.RX_PKT_VLD_OUT), 72'h0);

        frame3(32'hFB00_0002, 32'h1234_5678, 32'hFD00_BF4F);
        gap();
        chk("crc.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h0);
        chk_cnts("crc", 1, 1, 0, 0);

        // ch7 with payload: FB05 ^ FFFF ^ 6042 = 64B8
        word(32'hFB02_0007, 4'b1000);
        gap();
        word(32'hAAAA_5555, 4'b0000);
        word(32'hBC12_3456, 4'b1000);
        word(32'hDEAD_BEEF, 4'b0000);
        gap();
        word(32'hBC00_0000, 4'b1000);
        word(32'hFD00_64B8, 4'b1000);
        gap();
        chk("payload.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h80);
        chk("payload.dat", bus.RX_PKT_DATA_OUT[7*PKT_BITS +: PKT_BITS], {32'hDEAD_BEEF, 32'hAAAA_5555, 8'h02});
        chk_cnts("payload", 2, 1, 0, 0);
        gap();

        bus.RX_PKT_RDY_IN = 8'h00;
        frame3(32'hFB00_0000, 32'h0000_0001, 32'hFD00_FB01);
        gap();
        chk("hold.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h01);
        frame3(32'hFB00_0000, 32'h0000_0002, 32'hFD00_FB02);
        gap();
        chk("drop.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h01);
        chk("drop.dat", bus.RX_PKT_DATA_OUT[0 +: PKT_BITS], {32'h0, 32'h0000_0001, 8'h00});
        chk_cnts("drop", 4, 1, 0, 1);
        frame3(32'hFB00_0000, 32'h0000_0003, 32'hFD00_FB03);
        bus.RX_PKT_RDY_IN = 8'h01;
        gap();
        bus.RX_PKT_RDY_IN = 8'h00;
        chk("replace.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h01);
        chk("replace.dat", bus.RX_PKT_DATA_OUT[0 +: PKT_BITS], {32'h0, 32'h0000_0003, 8'h00});
        chk_cnts("replace", 5, 1, 0, 1);
        bus.RX_PKT_RDY_IN = 8'hFF;
        gap();
        chk("replace.consumed", 72'(bus.RX_PKT_VLD_OUT), 72'h0);

        word(32'hFB00_0002, 4'b1000);
        frame3(32'hFB00_0002, 32'h1234_5678, 32'hFD00_BF4E);
        gap();
        chk("resync.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h04);
        chk_cnts("resync", 6, 1, 1, 1);
        word(32'h1111_1111, 4'b0000);
        word(32'hFD00_BF4E, 4'b1000);
        gap();
        chk("hunt.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h0);
        chk_cnts("hunt", 6, 1, 1, 1);

        word(32'hFB00_0002, 4'b1000);
        word(32'h1234_5678, 4'b0000);
        word(32'hFD00_BF4E, 4'b1000);
        bus.HANDSHAKE_COMPLETE_IN = 1'b0;
        gap();
        bus.HANDSHAKE_COMPLETE_IN = 1'b1;
        word(32'hFD00_BF4E, 4'b1000);
        gap();
        chk("hs_low.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h0);
        chk_cnts("hs_low", 6, 1, 1, 1);
        frame3(32'hFB00_0002, 32'h1234_5678, 32'hFD00_BF4E);
        gap();
        chk("hs_clean.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h04);
        chk_cnts("hs_clean", 7, 1, 1, 1);

        bus.RX_PKT_RDY_IN = 8'h00;
        frame3(32'hFB00_0002, 32'h1234_5678, 32'hFD00_BF4E);
        gap();
        chk("prerst.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h04);
        word(32'hFB00_0002, 4'b1000);
        word(32'h1234_5678, 4'b0000);
        gap();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h0);
        chk("rst.dat_ch2", bus.RX_PKT_DATA_OUT[2*PKT_BITS +: PKT_BITS], 72'h0);
        chk_cnts("rst", 0, 0, 0, 0);
        word(32'hFD00_BF4E, 4'b1000);
        gap();
        chk("rst_eof.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h0);
        bus.RX_PKT_RDY_IN = 8'hFF;
        frame3(32'hFB00_0002, 32'h1234_5678, 32'hFD00_BF4E);
        gap();
        chk("rst_clean.vld", 72'(bus.RX_PKT_VLD_OUT), 72'h04);
        chk("rst_clean.dat", bus.RX_PKT_DATA_OUT[2*PKT_BITS +: PKT_BITS], {32'h0, 32'h1234_5678, 8'h00});
        chk_cnts("rst_clean", 1, 0, 0, 0);
        gap();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
